// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and the
// default abort limit for an unanswered memory request.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } lsu_state_t;

  localparam int LSU_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int XLEN = 32
) ();

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/lsu_watchdog.sv
// Counts cycles spent waiting in REQ and flags the last permitted cycle so the
// FSM can abort a request that memory never acknowledges.
module lsu_watchdog
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES
) (
  input  logic CLK,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  // Cycle counter: zeroed when a request is launched, advances while waiting.
  always_ff @(posedge CLK) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Counter starts at 0 in the first REQ cycle, so TIMEOUT_CYCLES-1 marks the
  // final cycle that memory is still allowed to answer in.
  assign expired = enable && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding lw/sw engine: computes the effective address, issues one
// data-memory request, and writes load results back to the register file.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES,
  parameter int XLEN           = 32
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [XLEN-1:0]       base,
  input  logic [XLEN-1:0]       imm,
  input  logic [XLEN-1:0]       store_data,
  input  logic [4:0]            rd,
  load_store_unit_if.master     mem,
  output logic                  rf_we,
  output logic [4:0]            rf_a3,
  output logic [XLEN-1:0]       rf_wd,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  lsu_state_t      state_reg, state_next;
  logic [XLEN-1:0] addr_sum;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] rdata_reg;
  logic [4:0]      rd_reg;
  logic            store_reg;
  logic            accept;
  logic            in_req;
  logic            wd_expired;

  // Carry out of the address add is dropped: addresses wrap modulo 2^XLEN.
  assign addr_sum = base + imm;
  assign accept   = (state_reg == IDLE) && start;
  assign in_req   = (state_reg == REQ);

  lsu_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .CLK     (CLK),
    .rst     (rst),
    .clear   (accept),
    .enable  (in_req),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; an ack in the final permitted cycle wins over the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = (addr_sum[1:0] != 2'b00) ? ERR : REQ;
      REQ: begin
        if (mem.mem_ack)     state_next = WB;
        else if (wd_expired) state_next = ERR;
      end
      WB:      state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on accept, load data capture on ack; everything else holds.
  always_ff @(posedge CLK) begin
    if (rst) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      rd_reg    <= '0;
      store_reg <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg  <= addr_sum;
        wdata_reg <= store_data;
        rd_reg    <= rd;
        store_reg <= is_store;
      end
      if (in_req && mem.mem_ack && !store_reg) begin
        rdata_reg <= mem.mem_rdata;
      end
    end
  end

  // Request lines are only live in REQ; address/data hold their captured values.
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req && store_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;

  // x0 is hardwired zero, so a load targeting it completes without a write.
  assign rf_we = (state_reg == WB) && !store_reg && (rd_reg != 5'd0);
  assign rf_a3 = rd_reg;
  assign rf_wd = rdata_reg;

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == WB);
  assign err  = (state_reg == ERR);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of lw/sw transactions with
// hand-computed results, plus hand-written reset sequences.
module tb_load_store_unit;

  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic        CLK = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [31:0] base;
  logic [31:0] imm;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        busy;
  logic        done;
  logic        err;

  load_store_unit_if #(.XLEN(XLEN)) mem_bus ();

  load_store_unit #(
    .TIMEOUT_CYCLES (TO),
    .XLEN           (XLEN)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .base       (base),
    .imm        (imm),
    .store_data (store_data),
    .rd         (rd),
    .mem        (mem_bus),
    .rf_we      (rf_we),
    .rf_a3      (rf_a3),
    .rf_wd      (rf_wd),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_store;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] sd;
    logic [4:0]  rd;
    int          ack_delay;   // REQ cycles before ack; -1 means never
    logic [31:0] rdata;
    logic        stray;       // drive mem_ack outside REQ
    logic        try_start;   // pulse start while busy and in WB/ERR
    logic [31:0] exp_addr;
    logic        exp_err;
    logic        exp_rf_we;
    int          exp_req;     // cycles with mem_req=1
    int          exp_lat;     // cycles from start to done/err
  } vec_t;

  vec_t vecs[9];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          reqn;
    int          lat;
    int          post_bad;
    logic        got_done, got_err, end_rf_we, stable_ok, overlap_bad;
    logic [4:0]  end_a3;
    logic [31:0] end_wd, first_addr, first_wdata;
    logic        first_we;
    reqn = 0; lat = -1; stable_ok = 1'b1; overlap_bad = 1'b0;
    got_done = 1'b0; got_err = 1'b0; end_rf_we = 1'b0; end_a3 = '0; end_wd = '0;
    first_addr = '0; first_wdata = '0; first_we = 1'b0;

    @(posedge CLK); #1;
    chk($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
    start      = 1'b1;
    is_store   = v.is_store;
    base       = v.base;
    imm        = v.imm;
    store_data = v.sd;
    rd         = v.rd;
    mem_bus.mem_ack   = v.stray;
    mem_bus.mem_rdata = 32'hBAD0_BAD0;

    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      @(posedge CLK); #1;
      // scramble operands: the DUT must be working from its captured copy
      start      = v.try_start && busy;
      is_store   = ~v.is_store;
      base       = 32'h0000_0400 + 32'(cyc * 4);
      imm        = 32'h0000_0010;
      store_data = 32'hCAFE_F00D;
      rd         = 5'd9;
      if ((done || err) && mem_bus.mem_req) overlap_bad = 1'b1;
      if (rf_we && err) overlap_bad = 1'b1;
      if (mem_bus.mem_req) begin
        if (reqn == 0) begin
          first_addr  = mem_bus.mem_addr;
          first_we    = mem_bus.mem_we;
          first_wdata = mem_bus.mem_wdata;
        end else if (mem_bus.mem_addr !== first_addr || mem_bus.mem_we !== first_we ||
                     mem_bus.mem_wdata !== first_wdata) begin
          stable_ok = 1'b0;
        end
        mem_bus.mem_ack   = (reqn == v.ack_delay);
        mem_bus.mem_rdata = (reqn == v.ack_delay) ? v.rdata : 32'h0BAD_F00D;
        reqn++;
      end else begin
        mem_bus.mem_ack   = v.stray;
        mem_bus.mem_rdata = 32'hBAD0_BAD0;
      end
      if (done || err) begin
        lat       = cyc;
        got_done  = done;
        got_err   = err;
        end_rf_we = rf_we;
        end_a3    = rf_a3;
        end_wd    = rf_wd;
      end
    end

    // start during the WB/ERR cycle must not launch a new transaction
    start = v.try_start;
    @(posedge CLK); #1;
    start = 1'b0;
    mem_bus.mem_ack = 1'b0;

    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d_complete: got no done/err within 40 cycles, required latency %0d", idx, v.exp_lat);
    end else begin
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_done", idx), got_done, !v.exp_err);
      chk($sformatf("v%0d_err", idx), got_err, v.exp_err);
      chk($sformatf("v%0d_rf_we", idx), end_rf_we, v.exp_rf_we);
      if (v.exp_rf_we) begin
        chk($sformatf("v%0d_rf_a3", idx), end_a3, v.rd);
        chk($sformatf("v%0d_rf_wd", idx), end_wd, v.rdata);
      end
    end
    chk($sformatf("v%0d_req_cycles", idx), 32'(reqn), 32'(v.exp_req));
    if (v.exp_req > 0) begin
      chk($sformatf("v%0d_mem_addr", idx), first_addr, v.exp_addr);
      chk($sformatf("v%0d_mem_we", idx), first_we, v.is_store);
      if (v.is_store) chk($sformatf("v%0d_mem_wdata", idx), first_wdata, v.sd);
      chk($sformatf("v%0d_req_stable", idx), stable_ok, 1'b1);
    end
    chk($sformatf("v%0d_no_overlap", idx), overlap_bad, 1'b0);

    post_bad = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (mem_bus.mem_req || busy) post_bad++;
    end
    chk($sformatf("v%0d_post_idle", idx), 32'(post_bad), 32'd0);
    $display("vec %0d: store=%0d addr=0x%08h req=%0d lat=%0d done=%0d err=%0d rf_we=%0d",
             idx, v.is_store, first_addr, reqn, lat, got_done, got_err, end_rf_we);
  endtask

  initial begin
    int seen_bad;
    //            st    base          imm           sd            rd     dly  rdata         stray try  exp_addr     err   rfwe  req lat
    vecs[0] = '{1'b0, 32'h0000_0020, 32'h0000_0004, 32'h0,        5'd5,  3,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0024, 1'b0, 1'b1, 4,  5};
    vecs[1] = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFC, 32'h1234_5678, 5'd2,  0,  32'h0,         1'b0, 1'b0, 32'h0000_00FC, 1'b0, 1'b0, 1,  2};
    vecs[2] = '{1'b0, 32'h0000_0021, 32'h0000_0000, 32'h0,        5'd4,  0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 0,  1};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h0000_0010, 32'h0,        5'd7,  -1, 32'h0,         1'b0, 1'b0, 32'h0000_0050, 1'b1, 1'b0, 16, 17};
    vecs[4] = '{1'b0, 32'h0000_0008, 32'h0000_0008, 32'h0,        5'd0,  1,  32'h0000_0055, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 2,  3};
    vecs[5] = '{1'b0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0,        5'd31, 2,  32'hA5A5_A5A5, 1'b1, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 3,  4};
    vecs[6] = '{1'b0, 32'h0000_0003, 32'h0000_0001, 32'h0,        5'd1,  0,  32'h0000_0001, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b1, 1,  2};
    vecs[7] = '{1'b1, 32'h0000_0020, 32'h0000_0002, 32'h0BAD_0001, 5'd3, 0,  32'h0,         1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 0,  1};
    vecs[8] = '{1'b1, 32'h0000_0080, 32'h0000_0000, 32'h8765_4321, 5'd6, 15, 32'h0,         1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 16, 17};

    rst = 1'b1; start = 1'b0; is_store = 1'b0; base = '0; imm = '0; store_data = '0; rd = '0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_mem_req", mem_bus.mem_req, 1'b0);
    chk("rst_mem_we", mem_bus.mem_we, 1'b0);
    chk("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_a3", rf_a3, 5'd0);
    chk("rst_rf_wd", rf_wd, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // reset in the middle of a request abandons it
    @(posedge CLK); #1;
    start = 1'b1; is_store = 1'b0; base = 32'h0000_0200; imm = 32'h0; rd = 5'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("midrst_req_before", mem_bus.mem_req, 1'b1);
    @(posedge CLK); #1;
    rst = 1'b1;
    @(posedge CLK); #1;
    rst = 1'b0;
    chk("midrst_mem_req", mem_bus.mem_req, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mem_addr", mem_bus.mem_addr, 32'h0);
    seen_bad = 0;
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h1111_2222;
    repeat (3) begin
      if (done || rf_we || mem_bus.mem_req) seen_bad++;
      @(posedge CLK); #1;
    end
    mem_bus.mem_ack = 1'b0;
    chk("midrst_no_done_we", 32'(seen_bad), 32'd0);
    $display("midrst: abandoned lw rd=3 at 0x200, done/rf_we/req seen %0d times", seen_bad);

    // a normal load still completes afterwards
    run_vec(9, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
